regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 22 ++
 rtl/regfile_wb_arbiter_wb_fifo.sv | 91 +++++++++
 rtl/regfile_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter_pkg
//  Purpose  : Shared widths and requester encoding for the register-file
//             writeback arbiter and its per-requester queues.
//  Contents : REG_ADDR_W - register address width
//             DATA_W     - register data width
//             sel_e      - requester select (SEL_ALU / SEL_MEM)
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef enum logic {
      SEL_ALU = 1'b0,
      SEL_MEM = 1'b1
   } sel_e;

endpackage : regfile_wb_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : DEPTH-entry writeback queue (address + data) for one requester.
//             Every entry address and its occupied flag are exported so the
//             parent can run hazard compares against all queued writes.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             push, push_addr/data  - enqueue (ignored when full)
//             pop                   - dequeue head (ignored when empty)
//             full, empty           - occupancy flags
//             head_addr, head_data  - oldest entry
//             entry_addr            - all slot addresses, slot i at [i*5 +: 5]
//             entry_valid           - per-slot occupied flag
//  Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [REG_ADDR_W-1:0]         push_addr,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic                          full,
   output logic                          empty,
   output logic [REG_ADDR_W-1:0]         head_addr,
   output logic [DATA_W-1:0]             head_data,
   output logic [DEPTH*REG_ADDR_W-1:0]   entry_addr,
   output logic [DEPTH-1:0]              entry_valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] c_depth = CW'(DEPTH);

   logic [REG_ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0]     r_data [DEPTH];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;

   logic w_push;
   logic w_pop;

   assign full   = (r_count == c_depth);
   assign empty  = (r_count == '0);
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   assign head_addr = r_addr[r_rptr];
   assign head_data = r_data[r_rptr];

   // Pointers are PW bits wide and DEPTH is a power of two, so plain
   // increment wraps modulo DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + CW'(1);
         else if (!w_push && w_pop)
            r_count <= r_count - CW'(1);
      end
   end

   // Storage needs no reset: stale slots are masked by entry_valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wptr] <= push_addr;
         r_data[r_wptr] <= push_data;
      end
   end

   // A slot is occupied when its distance from the read pointer is below
   // the occupancy count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [PW-1:0] w_off;
      assign w_off = PW'(i) - r_rptr;
      assign entry_addr[i*REG_ADDR_W +: REG_ADDR_W] = r_addr[i];
      assign entry_valid[i] = ({1'b0, w_off} < r_count);
   end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Merges ALU and load writebacks into the single register-file
//             write port. Each requester has its own queue; one head is
//             popped per cycle, round-robin when both queues hold entries.
//             Also flags read/write hazards against all pending writes.
//  Ports    : clk, rst_n                         - clock, async active-low reset
//             alu_valid/ready/addr/data          - ALU writeback request
//             mem_valid/ready/addr/data          - load writeback request
//             RegWrite/Write_register/Write_data - registered write port
//             Inst_B, Inst_C                     - read addresses to check
//             hazard1, hazard2                   - pending write to Inst_B/C
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [4:0]            alu_addr,
   input  logic [31:0]           alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [4:0]            mem_addr,
   input  logic [31:0]           mem_data,
   output logic                  RegWrite,
   output logic [4:0]            Write_register,
   output logic [31:0]           Write_data,
   input  logic [4:0]            Inst_B,
   input  logic [4:0]            Inst_C,
   output logic                  hazard1,
   output logic                  hazard2
);

   logic                        w_alu_full, w_alu_empty, w_mem_full, w_mem_empty;
   logic [REG_ADDR_W-1:0]       w_alu_head_addr, w_mem_head_addr;
   logic [DATA_W-1:0]           w_alu_head_data, w_mem_head_data;
   logic [DEPTH*REG_ADDR_W-1:0] w_alu_entry_addr, w_mem_entry_addr;
   logic [DEPTH-1:0]            w_alu_entry_valid, w_mem_entry_valid;
   logic                        w_pop_alu, w_pop_mem, w_both;
   logic [REG_ADDR_W-1:0]       w_pop_addr;
   logic [DATA_W-1:0]           w_pop_data;
   logic                        w_hit_b, w_hit_c;

   sel_e                        r_rr;
   logic                        r_reg_write;
   logic [REG_ADDR_W-1:0]       r_write_register;
   logic [DATA_W-1:0]           r_write_data;

   // Ready is purely "not full": a pop in the same edge does not free a slot.
   assign alu_ready = !w_alu_full;
   assign mem_ready = !w_mem_full;

   wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (alu_valid),
      .push_addr   (alu_addr),
      .push_data   (alu_data),
      .pop         (w_pop_alu),
      .full        (w_alu_full),
      .empty       (w_alu_empty),
      .head_addr   (w_alu_head_addr),
      .head_data   (w_alu_head_data),
      .entry_addr  (w_alu_entry_addr),
      .entry_valid (w_alu_entry_valid)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (mem_valid),
      .push_addr   (mem_addr),
      .push_data   (mem_data),
      .pop         (w_pop_mem),
      .full        (w_mem_full),
      .empty       (w_mem_empty),
      .head_addr   (w_mem_head_addr),
      .head_data   (w_mem_head_data),
      .entry_addr  (w_mem_entry_addr),
      .entry_valid (w_mem_entry_valid)
   );

   assign w_both = !w_alu_empty && !w_mem_empty;

   always_comb begin
      w_pop_alu = 1'b0;
      w_pop_mem = 1'b0;
      if (w_both) begin
         if (r_rr == SEL_MEM) w_pop_mem = 1'b1;
         else                 w_pop_alu = 1'b1;
      end else if (!w_alu_empty) begin
         w_pop_alu = 1'b1;
      end else if (!w_mem_empty) begin
         w_pop_mem = 1'b1;
      end
   end

   assign w_pop_addr = w_pop_mem ? w_mem_head_addr : w_alu_head_addr;
   assign w_pop_data = w_pop_mem ? w_mem_head_data : w_alu_head_data;

   // Pointer flips only on contended pops, so a lone requester never
   // steals the turn of the other side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr             <= SEL_MEM;
         r_reg_write      <= 1'b0;
         r_write_register <= '0;
         r_write_data     <= '0;
      end else begin
         if (w_both)
            r_rr <= (r_rr == SEL_MEM) ? SEL_ALU : SEL_MEM;
         if (w_pop_alu || w_pop_mem) begin
            r_write_register <= w_pop_addr;
            r_write_data     <= w_pop_data;
            // Register 0 is hardwired; its entries drain without a write.
            r_reg_write      <= (w_pop_addr != '0);
         end else begin
            r_reg_write      <= 1'b0;
         end
      end
   end

   assign RegWrite       = r_reg_write;
   assign Write_register = r_write_register;
   assign Write_data     = r_write_data;

   // A read is hazardous if any queued entry or the write currently on the
   // port targets the same (non-zero) register.
   always_comb begin
      w_hit_b = r_reg_write && (r_write_register == Inst_B);
      w_hit_c = r_reg_write && (r_write_register == Inst_C);
      for (int i = 0; i < DEPTH; i++) begin
         if (w_alu_entry_valid[i] &&
             (w_alu_entry_addr[i*REG_ADDR_W +: REG_ADDR_W] == Inst_B)) w_hit_b = 1'b1;
         if (w_mem_entry_valid[i] &&
             (w_mem_entry_addr[i*REG_ADDR_W +: REG_ADDR_W] == Inst_B)) w_hit_b = 1'b1;
         if (w_alu_entry_valid[i] &&
             (w_alu_entry_addr[i*REG_ADDR_W +: REG_ADDR_W] == Inst_C)) w_hit_c = 1'b1;
         if (w_mem_entry_valid[i] &&
             (w_mem_entry_addr[i*REG_ADDR_W +: REG_ADDR_W] == Inst_C)) w_hit_c = 1'b1;
      end
   end

   assign hazard1 = (Inst_B != '0) && w_hit_b;
   assign hazard2 = (Inst_C != '0) && w_hit_c;

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Self-checking bench for regfile_wb_arbiter. A queue-based
//             model predicts ready, write port and hazard outputs; directed
//             scenarios pin the model with literal expectations, followed
//             by randomized traffic with occasional resets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid = 1'b0, mem_valid = 1'b0;
   logic [4:0]  alu_addr = '0, mem_addr = '0, Inst_B = '0, Inst_C = '0;
   logic [31:0] alu_data = '0, mem_data = '0;
   logic        alu_ready, mem_ready, RegWrite, hazard1, hazard2;
   logic [4:0]  Write_register;
   logic [31:0] Write_data;

   regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_addr       (alu_addr),
      .alu_data       (alu_data),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .RegWrite       (RegWrite),
      .Write_register (Write_register),
      .Write_data     (Write_data),
      .Inst_B         (Inst_B),
      .Inst_C         (Inst_C),
      .hazard1        (hazard1),
      .hazard2        (hazard2)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        qa[$];
   ent_t        qm[$];
   bit          m_mem_next;     // contended pop goes to MEM when set
   bit          m_we;
   logic [4:0]  m_wr;
   logic [31:0] m_wd;
   logic [31:0] m_regs [32];
   logic [31:0] d_regs [32];
   bit          last_acc_a, last_acc_m;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit hz(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      foreach (qa[i]) if (qa[i].a == r) return 1'b1;
      foreach (qm[i]) if (qm[i].a == r) return 1'b1;
      return m_we && (m_wr == r);
   endfunction

   // Advance the model over the coming rising edge using the inputs now applied.
   task automatic model_edge();
      ent_t e;
      bit   popped;
      if (!rst_n) begin
         qa.delete();
         qm.delete();
         m_mem_next = 1'b1;
         m_we = 1'b0;
         m_wr = '0;
         m_wd = '0;
         last_acc_a = 1'b0;
         last_acc_m = 1'b0;
         return;
      end
      last_acc_a = alu_valid && (qa.size() < DEPTH);
      last_acc_m = mem_valid && (qm.size() < DEPTH);
      popped = 1'b1;
      if (qa.size() != 0 && qm.size() != 0) begin
         e = m_mem_next ? qm.pop_front() : qa.pop_front();
         m_mem_next = !m_mem_next;
      end else if (qa.size() != 0) begin
         e = qa.pop_front();
      end else if (qm.size() != 0) begin
         e = qm.pop_front();
      end else begin
         popped = 1'b0;
      end
      if (last_acc_a) qa.push_back('{a: alu_addr, d: alu_data});
      if (last_acc_m) qm.push_back('{a: mem_addr, d: mem_data});
      if (popped) begin
         m_wr = e.a;
         m_wd = e.d;
         m_we = (e.a != 5'd0);
         if (m_we) m_regs[m_wr] = m_wd;
      end else begin
         m_we = 1'b0;
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   task automatic compare();
      chk("alu_ready", alu_ready, (qa.size() < DEPTH));
      chk("mem_ready", mem_ready, (qm.size() < DEPTH));
      chk("RegWrite", RegWrite, m_we);
      chk("Write_register", Write_register, m_wr);
      chk("Write_data", Write_data, m_wd);
      chk("hazard1", hazard1, hz(Inst_B));
      chk("hazard2", hazard2, hz(Inst_C));
      if (RegWrite === 1'b1) d_regs[Write_register] = Write_data;
   endtask

   task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] ib, input logic [4:0] ic);
      compare();
      #1;
      alu_valid = av; alu_addr = aa; alu_data = ad;
      mem_valid = mv; mem_addr = ma; mem_data = md;
      Inst_B = ib; Inst_C = ic;
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic [4:0] ib, input logic [4:0] ic);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, ib, ic);
   endtask

   // Change reset mid-cycle; on assertion check the asynchronous clear at once.
   task automatic set_rst(input bit v);
      compare();
      #1;
      alu_valid = 1'b0; mem_valid = 1'b0;
      rst_n = v;
      #1;
      if (!v) begin
         chk("arst_RegWrite", RegWrite, 0);
         chk("arst_Write_register", Write_register, 0);
         chk("arst_Write_data", Write_data, 0);
         chk("arst_alu_ready", alu_ready, 1);
         chk("arst_mem_ready", mem_ready, 1);
         chk("arst_hazard1", hazard1, 0);
         chk("arst_hazard2", hazard2, 0);
      end
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      bit saw_mem_block;
      int na, nm, guard;
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         d_regs[i] = '0;
      end
      model_edge();                       // rst_n low: model in reset state
      @(negedge clk);
      chk("reset_RegWrite", RegWrite, 0);
      chk("reset_alu_ready", alu_ready, 1);
      chk("reset_mem_ready", mem_ready, 1);
      chk("reset_Write_data", Write_data, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      model_edge();
      @(negedge clk);

      // Single ALU write: visible exactly one cycle after acceptance.
      step(1, 5'd1, 32'd200, 0, 0, 0, 0, 0);
      chk("single_before", RegWrite, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("single_we", RegWrite, 1);
      chk("single_wr", Write_register, 1);
      chk("single_wd", Write_data, 200);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("single_pulse_end", RegWrite, 0);
      chk("single_reg1_dut", d_regs[1], 200);
      chk("single_reg1_model", m_regs[1], 200);

      // Contention: MEM wins first after reset, ALU next.
      step(1, 5'd2, 32'd300, 1, 5'd3, 32'd400, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("cont_first_wr", Write_register, 3);
      chk("cont_first_wd", Write_data, 400);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("cont_second_wr", Write_register, 2);
      chk("cont_second_wd", Write_data, 300);
      chk("cont_second_we", RegWrite, 1);
      for (int i = 0; i < 6; i++)
         step(1, 5'(8 + i), 32'(1000 + i), 1, 5'(16 + i), 32'(2000 + i), 0, 0);
      idle(6, 0, 0);

      // Zero register: drains with no write, no hazard on register 0.
      step(1, 5'd0, 32'd55, 0, 0, 0, 0, 0);
      chk("zero_hazard", hazard1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("zero_no_write", RegWrite, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("zero_reg0", d_regs[0], 0);

      // Hazard tracking through queue and write stage.
      step(0, 0, 0, 1, 5'd2, 32'd300, 5'd2, 5'd3);
      chk("hz_queued_1", hazard1, 1);
      chk("hz_queued_2", hazard2, 0);
      step(0, 0, 0, 0, 0, 0, 5'd2, 5'd3);
      chk("hz_write_we", RegWrite, 1);
      chk("hz_write_1", hazard1, 1);
      step(0, 0, 0, 0, 0, 0, 5'd2, 5'd3);
      chk("hz_after_1", hazard1, 0);

      // Backpressure: ALU stream of 4 keeps the port busy while MEM is held.
      saw_mem_block = 1'b0;
      na = 0; nm = 0; guard = 0;
      while ((na < 4 || nm < 6) && guard < 40) begin
         step(na < 4, 5'(4 + na), 32'(500 + na), nm < 6, 5'(20 + nm), 32'(600 + nm), 0, 0);
         if (last_acc_a) na++;
         if (last_acc_m) nm++;
         if (mem_ready === 1'b0) saw_mem_block = 1'b1;
         guard++;
      end
      chk("bp_mem_ready_dropped", saw_mem_block, 1);
      idle(8, 0, 0);

      // Reset with two entries queued: nothing from them may be written.
      step(1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 5'd5, 5'd6);
      set_rst(0);
      set_rst(1);
      idle(5, 5'd5, 5'd6);
      chk("rst_no_write_reg5", d_regs[5], m_regs[5]);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            set_rst(0);
            set_rst(1);
         end else begin
            step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         end
      end
      idle(8, 0, 0);
      compare();
      for (int r = 0; r < 32; r++) chk("regfile_image", d_regs[r], m_regs[r]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
